// File: rtl/imem_program_loader.sv
// Streams instruction words into imem from address 0, holding the core in reset
// until RESET_HOLD cycles after the final write.
module imem_program_loader #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RESET_HOLD = 4
) (
   input  logic                  clock,
   input  logic                  ctrl_reset,
   input  logic                  load_start,
   input  logic [ADDR_WIDTH:0]   load_count,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  imem_wren,
   output logic [ADDR_WIDTH-1:0] imem_address,
   output logic [DATA_WIDTH-1:0] imem_data,
   output logic                  proc_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

   typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

   state_t              state;
   logic [ADDR_WIDTH:0] wordTotal;
   logic [ADDR_WIDTH:0] wordCnt;
   logic [ADDR_WIDTH:0] nextCnt;
   logic [HOLD_W-1:0]   holdCnt;
   logic                countValid;
   logic                accept;

   assign countValid = (load_count != '0) && (load_count <= DEPTH);
   assign nextCnt    = wordCnt + ONE;
   // in_ready is a registered copy of (state == LOAD), so accept never depends
   // combinationally on in_valid through the ready path.
   assign accept     = in_valid && in_ready;

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         state        <= IDLE;
         wordTotal    <= '0;
         wordCnt      <= '0;
         holdCnt      <= '0;
         in_ready     <= 1'b0;
         imem_wren    <= 1'b0;
         imem_address <= '0;
         imem_data    <= '0;
         proc_reset   <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
      end else begin
         imem_wren <= 1'b0;
         unique case (state)
            IDLE, RUN: begin
               if (load_start) begin
                  if (countValid) begin
                     state      <= LOAD;
                     wordTotal  <= load_count;
                     wordCnt    <= '0;
                     error      <= 1'b0;
                     in_ready   <= 1'b1;
                     busy       <= 1'b1;
                     done       <= 1'b0;
                     proc_reset <= 1'b1;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  imem_wren    <= 1'b1;
                  imem_address <= wordCnt[ADDR_WIDTH-1:0];
                  imem_data    <= in_data;
                  wordCnt      <= nextCnt;
                  if (nextCnt == wordTotal) begin
                     state    <= HOLD;
                     in_ready <= 1'b0;
                     holdCnt  <= '0;
                  end
               end
            end
            HOLD: begin
               if (holdCnt == HOLD_LAST) begin
                  state      <= RUN;
                  proc_reset <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end else begin
                  holdCnt <= holdCnt + HOLD_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_program_loader.sv
// Randomized self-checking bench for imem_program_loader; expected writes and
// release timing are derived from the word list and the hold length.
module tb_imem_program_loader;

   localparam int unsigned AW  = 12;
   localparam int unsigned DW  = 32;
   localparam int unsigned RH  = 4;
   localparam int unsigned LCW = AW + 1;

   logic           clock = 1'b0;
   logic           ctrlReset;
   logic           loadStart;
   logic [AW:0]    loadCount;
   logic           inValid;
   logic [DW-1:0]  inData;
   logic           inReady;
   logic           imemWren;
   logic [AW-1:0]  imemAddress;
   logic [DW-1:0]  imemData;
   logic           procReset;
   logic           busy;
   logic           done;
   logic           error;

   int             tests = 0;
   int             fails = 0;
   logic [DW-1:0]  words[$];

   imem_program_loader #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .RESET_HOLD(RH)
   ) dut (
      .clock(clock),
      .ctrl_reset(ctrlReset),
      .load_start(loadStart),
      .load_count(loadCount),
      .in_valid(inValid),
      .in_data(inData),
      .in_ready(inReady),
      .imem_wren(imemWren),
      .imem_address(imemAddress),
      .imem_data(imemData),
      .proc_reset(procReset),
      .busy(busy),
      .done(done),
      .error(error)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue a load of the words queue and follow it through to RUN.
   task automatic run_load(input int gapMax, input int gapAt, input int gapLen);
      int n;
      int g;
      int k;
      n = words.size();
      loadStart = 1'b1;
      loadCount = LCW'(n);
      inValid   = 1'b0;
      tick();
      loadStart = 1'b0;
      tests++;
      if ({inReady, busy, done, error, procReset} !== 5'b11001) begin
         fails++;
         $display("FAIL load_start_response: {rdy,busy,done,err,prst}=%b want 11001", {inReady, busy, done, error, procReset});
      end
      for (int i = 0; i < n; i++) begin
         g = (i == gapAt) ? gapLen : ((gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0);
         for (int j = 0; j < g; j++) begin
            inValid   = 1'b0;
            inData    = $urandom;
            loadStart = 1'($urandom_range(1, 0));
            loadCount = '0;
            tick();
            tests++;
            if ({imemWren, inReady, busy, error} !== 4'b0110) begin
               fails++;
               $display("FAIL gap_cycle word %0d: {wren,rdy,busy,err}=%b want 0110", i, {imemWren, inReady, busy, error});
            end
         end
         loadStart = 1'b0;
         inValid   = 1'b1;
         inData    = words[i];
         tick();
         tests++;
         if (imemWren !== 1'b1 || imemAddress !== AW'(i) || imemData !== words[i]) begin
            fails++;
            $display("FAIL imem_write %0d: wren=%b addr=%0d data=%h want wren=1 addr=%0d data=%h",
                     i, imemWren, imemAddress, imemData, i, words[i]);
         end
         tests++;
         if ({inReady, busy, procReset} !== {(i < n - 1), 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL ready_after_accept %0d: {rdy,busy,prst}=%b want %b%b%b", i, {inReady, busy, procReset}, (i < n - 1), 1'b1, 1'b1);
         end
      end
      inValid = 1'b0;
      k = 1;
      while (procReset === 1'b1 && k < int'(RH) + 10) begin
         loadStart = 1'($urandom_range(1, 0));
         loadCount = '0;
         tick();
         k++;
         if (procReset === 1'b1) begin
            tests++;
            if ({imemWren, inReady, busy, done} !== 4'b0010) begin
               fails++;
               $display("FAIL hold_cycle %0d: {wren,rdy,busy,done}=%b want 0010", k, {imemWren, inReady, busy, done});
            end
         end
      end
      loadStart = 1'b0;
      tests++;
      if (k !== int'(RH) + 1) begin
         fails++;
         $display("FAIL release_latency: cycles=%0d want %0d", k, RH + 1);
      end
      tests++;
      if ({done, busy, inReady, error, procReset} !== 5'b10000) begin
         fails++;
         $display("FAIL run_state: {done,busy,rdy,err,prst}=%b want 10000", {done, busy, inReady, error, procReset});
      end
   endtask

   task automatic test_reset();
      ctrlReset = 1'b1;
      loadStart = 1'b0;
      loadCount = '0;
      inValid   = 1'b0;
      inData    = '0;
      tick();
      tick();
      tests++;
      if ({procReset, inReady, imemWren, busy, done, error} !== 6'b100000) begin
         fails++;
         $display("FAIL reset_state: {prst,rdy,wren,busy,done,err}=%b want 100000", {procReset, inReady, imemWren, busy, done, error});
      end
      ctrlReset = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      words = '{32'h0000_0001, 32'h0001_0002, 32'hFFFF_FFFF};
      run_load(0, -1, 0);
   endtask

   task automatic test_gap();
      words.delete();
      for (int i = 0; i < 4; i++) words.push_back($urandom);
      run_load(0, 1, 3);
   endtask

   task automatic test_bad_count();
      logic [AW:0] bad[2];
      bad[0] = '0;
      bad[1] = LCW'(4097);
      for (int b = 0; b < 2; b++) begin
         loadStart = 1'b1;
         loadCount = bad[b];
         tick();
         loadStart = 1'b0;
         tick();
         tests++;
         if ({error, busy, inReady, procReset, done} !== 5'b10010) begin
            fails++;
            $display("FAIL bad_count_idle %0d: {err,busy,rdy,prst,done}=%b want 10010", bad[b], {error, busy, inReady, procReset, done});
         end
      end
      words = '{32'hA5A5_0001, 32'h5A5A_0002};
      run_load(1, -1, 0);
      loadStart = 1'b1;
      loadCount = '0;
      tick();
      loadStart = 1'b0;
      tests++;
      if ({error, done, procReset, busy} !== 4'b1100) begin
         fails++;
         $display("FAIL bad_count_run: {err,done,prst,busy}=%b want 1100", {error, done, procReset, busy});
      end
   endtask

   task automatic test_reload_from_run();
      words.delete();
      for (int i = 0; i < 2; i++) words.push_back($urandom);
      run_load(2, -1, 0);
   endtask

   task automatic test_reset_mid_load();
      loadStart = 1'b1;
      loadCount = LCW'(5);
      tick();
      loadStart = 1'b0;
      for (int i = 0; i < 2; i++) begin
         inValid = 1'b1;
         inData  = $urandom;
         tick();
      end
      inValid   = 1'b1;
      inData    = 32'hDEAD_BEEF;
      ctrlReset = 1'b1;
      tick();
      ctrlReset = 1'b0;
      inValid   = 1'b0;
      tests++;
      if ({imemWren, procReset, busy, inReady, done} !== 5'b01000) begin
         fails++;
         $display("FAIL reset_mid_load: {wren,prst,busy,rdy,done}=%b want 01000", {imemWren, procReset, busy, inReady, done});
      end
      tick();
      words = '{32'h1234_5678};
      run_load(0, -1, 0);
   endtask

   task automatic test_random();
      int n;
      for (int r = 0; r < 6; r++) begin
         n = int'($urandom_range(20, 1));
         words.delete();
         for (int i = 0; i < n; i++) words.push_back($urandom);
         run_load(3, -1, 0);
      end
   endtask

   task automatic test_full_depth();
      words.delete();
      for (int i = 0; i < (1 << AW); i++) words.push_back($urandom);
      run_load(0, -1, 0);
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gap();
      test_reset();
      test_bad_count();
      test_reload_from_run();
      test_reset();
      test_reset_mid_load();
      test_random();
      test_full_depth();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer-side counterpart to the processor's instruction fetch path.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them sequentially into instruction memory starting at address 0.
- Holds the processor in reset while loading, then releases it a fixed number of cycles after the last write.
- Sits between the bench/host program source and the imem write port in the skeleton.

Parameters:
ADDR_WIDTH, 12, imem address width; memory depth = 2^ADDR_WIDTH words
DATA_WIDTH, 32, instruction word width
RESET_HOLD, 4, cycles proc_reset stays high after the last imem write

Ports:
clock  input  1  single system clock, all state updates on posedge
ctrl_reset  input  1  synchronous reset, active-high
load_start  input  1  one-cycle request to begin a load; sampled in IDLE/RUN only
load_count  input  ADDR_WIDTH+1  number of words to load; valid range 1..2^ADDR_WIDTH
in_valid  input  1  in_data holds a word
in_data  input  DATA_WIDTH  instruction word
in_ready  output  1  loader accepts a word this cycle
imem_wren  output  1  instruction memory write enable
imem_address  output  ADDR_WIDTH  write address
imem_data  output  DATA_WIDTH  write data
proc_reset  output  1  reset to processor core
busy  output  1  high in LOAD or HOLD
done  output  1  high in RUN
error  output  1  sticky flag for an invalid load_count

Behaviour:
- States: IDLE, LOAD, HOLD, RUN.
- Reset (ctrl_reset high at posedge):
  - State goes to IDLE.
  - Word counter and hold counter go to 0.
  - imem_wren, imem_address, imem_data, busy, done and error go to 0.
  - proc_reset goes to 1.
  - Reset takes priority over every other input.
- IDLE:
  - proc_reset=1, in_ready=0.
  - load_start with a valid count: latch load_count, clear word counter, clear error, go to LOAD.
- LOAD:
  - in_ready=1 (decoded from state only, no combinational path from in_valid).
  - A word is accepted on a posedge with in_valid && in_ready.
  - Next cycle: imem_wren=1, imem_address=counter value at acceptance, imem_data=accepted word. Write latency is exactly 1 cycle.
  - The counter increments on each accept.
  - in_valid low: no accept; imem_wren=0 the following cycle. Gaps of any length are allowed.
  - Acceptance of word load_count-1 moves the state to HOLD on the same edge, so in_ready is low on the next cycle.
- HOLD:
  - proc_reset=1, in_ready=0.
  - The first HOLD cycle carries the final imem write.
  - The hold counter counts HOLD cycles. After RESET_HOLD cycles, go to RUN.
- RUN:
  - proc_reset=0, done=1.
  - load_start with a valid count: go to LOAD; proc_reset=1 and done=0 from the next cycle.
- load_start handling:
  - Ignored in LOAD and HOLD.
  - In IDLE/RUN with load_count==0 or >2^ADDR_WIDTH: error=1 (sticky), state unchanged.
  - error clears only on reset or the next valid load_start.
- Addressing:
  - Address never wraps, because load_count ≤ depth.
  - A full-depth load ends at address 2^ADDR_WIDTH-1.
- Output decoding: busy=(LOAD|HOLD); done=RUN.
- Reset mid-LOAD/HOLD:
  - The next cycle is IDLE with imem_wren=0.
  - Words already written remain in memory; the loader does not erase them.
- Simultaneous in_valid and ctrl_reset: the word is not accepted and not written.

Test Plan:
- Assert ctrl_reset for 2 cycles -> proc_reset=1, in_ready=0, imem_wren=0, busy=0, done=0, error=0.
- load_start, load_count=3; stream 0x00000001, 0x00010002, 0xFFFFFFFF back-to-back -> imem writes to addresses 0,1,2 with those data, each one cycle after acceptance. in_ready falls after the 3rd accept. proc_reset falls exactly 4 cycles after the first HOLD cycle; done=1.
- load_count=4 with in_valid low for 3 cycles between words 1 and 2 -> no writes during the gap; addresses stay contiguous 0..3; busy stays high throughout.
- In IDLE, load_start with load_count=0, then with load_count=4097 (ADDR_WIDTH=12) -> error=1, state remains IDLE, proc_reset=1. A following valid load_start clears error.
- Reset asserted after 2 of 5 words -> IDLE next cycle, imem_wren=0, proc_reset=1. A new load of 1 word writes address 0.
- From RUN, load_start with load_count=2 -> proc_reset=1 next cycle. New words are written at addresses 0,1 and done reasserts after the hold period.
